// File: rtl/breadboard_sequencer.sv
// Clocked 16-row self-test sweep of the 4-in/10-out breadboard with valid/ready row
// streaming and a rotate-xor signature. Optional golden compare: BREADBOARD_SEQ_GOLDEN_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for start; inputs parked at 0000
// SETTLE | row index driven, counting down the settle time
// OUT    | captured row presented, waiting for row_ready
// DONE   | one-cycle completion pulse
module breadboard_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        w,
    output logic        x,
    output logic        y,
    output logic        z,
    input  logic [9:0]  f,
    output logic        row_valid,
    input  logic        row_ready,
    output logic [3:0]  row_idx,
    output logic [9:0]  row_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature
`ifdef BREADBOARD_SEQ_GOLDEN_CHECK_EN
    ,
    input  logic [15:0] golden,
    output logic        pass
`endif
);

    localparam logic [7:0] SETTLE_LOAD = (SETTLE_CYCLES < 1)   ? 8'd1   :
                                         (SETTLE_CYCLES > 255) ? 8'd255 :
                                         8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, OUT, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        row_valid_d, busy_d, done_d;
    logic [3:0]  row_idx_d;
    logic [9:0]  row_data_d;
    logic [15:0] sig_d;

    assign {w, x, y, z} = idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            row_valid <= 1'b0;
            row_idx   <= '0;
            row_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            signature <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            row_valid <= row_valid_d;
            row_idx   <= row_idx_d;
            row_data  <= row_data_d;
            busy      <= busy_d;
            done      <= done_d;
            signature <= sig_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        row_idx_d  = row_idx;
        row_data_d = row_data;
        sig_d      = signature;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    idx_d   = '0;
                    sig_d   = '0;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    row_data_d = f;
                    row_idx_d  = idx_q;
                    sig_d      = {signature[14:0], signature[15]} ^ {6'b0, f};
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (row_valid && row_ready) begin
                    if (idx_q == 4'd15) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        cnt_d   = SETTLE_LOAD;
                        state_d = SETTLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        // abort overrides everything, including a handshake in the same cycle
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            sig_d   = '0;
        end

        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        row_valid_d = (state_d == OUT);
    end

`ifdef BREADBOARD_SEQ_GOLDEN_CHECK_EN
    logic pass_d;

    always_comb begin
        pass_d = pass;
        if (state_q == IDLE && start) begin
            pass_d = 1'b0;
        end else if (state_q == DONE && !abort) begin
            pass_d = (signature == golden);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass <= 1'b0;
        end else begin
            pass <= pass_d;
        end
    end
`endif

endmodule
